// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester/register-file write-port bundle for regfile_write_arbiter.
// Requesters (master) drive req/addr/data/stall; the arbiter (slave) returns the grant and the write port.
interface regfile_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] data;
    logic                    stall;
    logic [N_REQ-1:0]        gnt;
    logic                    we;
    logic [ADDR_W-1:0]       waddr;
    logic [DATA_W-1:0]       wdata;

    modport master (output req, addr, data, stall, input gnt, we, waddr, wdata);
    modport slave  (input req, addr, data, stall, output gnt, we, waddr, wdata);
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing one register-file write port among N_REQ writers.
// Grants are registered single-cycle pulses; writes to register 0 are granted but never enabled.
module regfile_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     sel;
    logic              found;
    logic [N_REQ-1:0]  elig;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // The requester granted last cycle is masked so it can drop req without a double grant.
    assign elig     = bus.req & ~bus.gnt;
    assign sel_addr = bus.addr[int'(sel)*ADDR_W +: ADDR_W];
    assign sel_data = bus.data[int'(sel)*DATA_W +: DATA_W];

    always_comb begin
        found = 1'b0;
        sel   = ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && elig[PW'((int'(ptr) + k) % N_REQ)]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.gnt   <= '0;
            bus.we    <= 1'b0;
            bus.waddr <= '0;
            bus.wdata <= '0;
            ptr       <= PW'(N_REQ - 1);
        end else if (!bus.stall && found) begin
            bus.gnt   <= N_REQ'(1) << sel;
            bus.we    <= |sel_addr;
            bus.waddr <= sel_addr;
            bus.wdata <= sel_data;
            ptr       <= sel;
        end else begin
            bus.gnt <= '0;
            bus.we  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench with directed vectors plus a randomized fairness/property phase.
module tb_regfile_write_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [41:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    bit sb_on = 1'b1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic w, input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({g, w, a, d});
    endtask

    task automatic drain(input string name);
        repeat (4) @(posedge clk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: every grant pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        logic [41:0] e;
        if (sb_on && rst_n && bus.gnt != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected got=%h exp=none at %0t",
                         {bus.gnt, bus.we, bus.waddr, bus.wdata}, $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_grant", 64'({bus.gnt, bus.we, bus.waddr, bus.wdata}), 64'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int wait_cnt[N];
    int max_wait;
    int idx;
    logic [N-1:0] prev_gnt;

    initial begin
        bus.req = '0;
        bus.stall = 1'b0;
        bus.addr = '0;
        bus.data = '0;
        for (int i = 0; i < N; i++) begin
            bus.addr[i*AW +: AW] = AW'(i + 1);
            bus.data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 64'({bus.gnt, bus.we, bus.waddr, bus.wdata}), 64'd0);

        // Round robin with all four requesting; the fifth grant is killed by a mid-cycle reset.
        bus.req = 4'b1111;
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(4'b0001, 1'b1, 5'd1, 32'hA000_0000);
        push(4'b0010, 1'b1, 5'd2, 32'hA000_0001);
        push(4'b0100, 1'b1, 5'd3, 32'hA000_0002);
        push(4'b1000, 1'b1, 5'd4, 32'hA000_0003);
        repeat (5) @(posedge clk);
        #1;
        check("rr_wrap_gnt", 64'(bus.gnt), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_gnt", 64'(bus.gnt), 64'd0);
        check("rst_mid_we", 64'(bus.we), 64'd0);
        check("rst_mid_waddr", 64'(bus.waddr), 64'd0);
        check("rst_mid_wdata", 64'(bus.wdata), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(4'b0001, 1'b1, 5'd1, 32'hA000_0000);
        @(posedge clk);
        #1 bus.req = '0;
        drain("drain_reset");

        // Single requester 2.
        bus.addr[2*AW +: AW] = 5'd7;
        bus.data[2*DW +: DW] = 32'hFFFF_FFFF;
        push(4'b0100, 1'b1, 5'd7, 32'hFFFF_FFFF);
        bus.req = 4'b0100;
        @(posedge clk);
        #1 bus.req = '0;
        drain("drain_single");

        // Write to register 0 is granted but not enabled.
        bus.addr[1*AW +: AW] = 5'd0;
        bus.data[1*DW +: DW] = 32'hF0F0_F0F0;
        push(4'b0010, 1'b0, 5'd0, 32'hF0F0_F0F0);
        bus.req = 4'b0010;
        @(posedge clk);
        #1 bus.req = '0;
        drain("drain_r0");

        // Stall: nothing issued, write port holds; pointer (at 1) still favours 3 over 0 afterwards.
        bus.stall = 1'b1;
        bus.req = 4'b1001;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_gnt", 64'(bus.gnt), 64'd0);
            check("stall_we", 64'(bus.we), 64'd0);
            check("stall_hold", 64'({bus.waddr, bus.wdata}), 64'({5'd0, 32'hF0F0_F0F0}));
        end
        bus.stall = 1'b0;
        push(4'b1000, 1'b1, 5'd4, 32'hA000_0003);
        push(4'b0001, 1'b1, 5'd1, 32'hA000_0000);
        @(posedge clk);
        @(posedge clk);
        #1 bus.req = '0;
        drain("drain_stall");

        // Random requests/stalls with property and fairness checks.
        sb_on = 1'b0;
        max_wait = 0;
        prev_gnt = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (bus.gnt != '0) begin
                check("rnd_onehot", 64'($onehot(bus.gnt)), 64'd1);
                check("rnd_no_repeat", 64'(bus.gnt & prev_gnt), 64'd0);
                check("rnd_no_stall", 64'(bus.stall), 64'd0);
                idx = 0;
                for (int i = 0; i < N; i++) if (bus.gnt[i]) idx = i;
                check("rnd_req", 64'(bus.req[idx]), 64'd1);
                check("rnd_write", 64'({bus.we, bus.waddr, bus.wdata}),
                      64'({|bus.addr[idx*AW +: AW], bus.addr[idx*AW +: AW], bus.data[idx*DW +: DW]}));
            end else begin
                check("rnd_idle_we", 64'(bus.we), 64'd0);
            end
            for (int i = 0; i < N; i++) begin
                if (bus.gnt[i] || !bus.req[i]) wait_cnt[i] = 0;
                else if (!bus.stall) wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            prev_gnt = bus.gnt;
            bus.stall = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        bus.req[i] = 1'b1;
                        bus.addr[i*AW +: AW] = AW'($urandom_range(0, 31));
                        bus.data[i*DW +: DW] = $urandom;
                    end
                end else if (bus.gnt[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        bus.addr[i*AW +: AW] = AW'($urandom_range(0, 31));
                        bus.data[i*DW +: DW] = $urandom;
                    end else begin
                        bus.req[i] = 1'b0;
                    end
                end
            end
        end
        checks++;
        if (max_wait > 2 * N) begin
            failures++;
            $display("FAIL fair_max_wait got=%0d exp<=%0d", max_wait, 2 * N);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
